// File: rtl/if_prefetch_stage_pkg.sv
// Package if_pkg: shared definitions for the instruction-fetch prefetch stage.
//   - PC source encodings (sequential / branch / jump / exception)
//   - fetch_entry_t: one prefetched instruction with its PC and PC+step
//   - default values for the stage parameters
package if_pkg;

  localparam int          IF_AW_DEF       = 32;
  localparam int          IF_DW_DEF       = 32;
  localparam int          IF_DEPTH_DEF    = 4;
  localparam logic [31:0] IF_RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] IF_EXC_VEC_DEF  = 32'h0000_0008;

  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'b00,
    PCSRC_BR  = 2'b01,
    PCSRC_JMP = 2'b10,
    PCSRC_EXC = 2'b11
  } pcsrc_e;

  typedef struct packed {
    logic [IF_DW_DEF-1:0] inst;
    logic [IF_AW_DEF-1:0] pc;
    logic [IF_AW_DEF-1:0] pc4;
  } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_stage_queue.sv
// if_fetch_queue: synchronous FIFO of fetch entries with push/pop/flush.
//   clk, clrn   clock, asynchronous active-low reset
//   push/din    write one entry at the tail
//   pop/dout    remove the head entry; dout always shows the head slot
//   flush       empty the queue (wins over push/pop in the same cycle)
//   count       number of valid entries, 0..DEPTH
//   empty       count == 0
// DEPTH must be a power of two so the pointers wrap naturally.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int  DEPTH   = IF_DEPTH_DEF,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  entry_t                   din,
  output entry_t                   dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t          mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;

  // Pointer and occupancy bookkeeping; flush restarts the ring at slot 0.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are only meaningful while counted as valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_r[wr_ptr_r] <= din;
  end

  assign dout  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign empty = (count_r == CW'(0));

  if_fetch_queue_chk #(.DEPTH(DEPTH)) u_chk (
    .clk   (clk),
    .clrn  (clrn),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .count (count_r)
  );

endmodule

// if_fetch_queue_chk: protocol checks for the fetch queue.
module if_fetch_queue_chk #(
  parameter int DEPTH = 4
) (
  input logic                   clk,
  input logic                   clrn,
  input logic                   push,
  input logic                   pop,
  input logic                   flush,
  input logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;

  a_no_overflow: assert property (@(posedge clk) disable iff (!clrn)
    !(push && !flush && (count == CW'(DEPTH))));

  a_no_underflow: assert property (@(posedge clk) disable iff (!clrn)
    !(pop && !flush && (count == CW'(0))));

endmodule

// File: rtl/if_prefetch_stage.sv
// if_prefetch_stage: instruction-fetch stage with PC register, fixed one-cycle
// imem port and a DEPTH-entry prefetch queue feeding decode via valid/ready.
//   clk, clrn            clock, asynchronous active-low reset
//   pcsource, bpc, jpc   next-PC select (00 seq, 01 branch, 10 jump, 11 exception)
//   imem_req/imem_addr   fetch request, address = current PC
//   imem_rdata/rvalid    response, exactly one cycle after each request
//   dec_valid/dec_ready  handshake towards decode
//   inst, pc, pc4        head entry (all zero while dec_valid is low)
//   misalign             present only with IF_ALIGN_CHK_EN defined
// Build option IF_ALIGN_CHK_EN: misaligned redirect targets are replaced by
// EXC_VEC and flagged on misalign; otherwise low target bits are cleared.
module if_prefetch_stage
  import if_pkg::*;
#(
  parameter int            AW       = IF_AW_DEF,
  parameter int            DW       = IF_DW_DEF,
  parameter int            DEPTH    = IF_DEPTH_DEF,
  parameter logic [AW-1:0] RESET_PC = AW'(IF_RESET_PC_DEF),
  parameter logic [AW-1:0] EXC_VEC  = AW'(IF_EXC_VEC_DEF)
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic [1:0]    pcsource,
  input  logic [AW-1:0] bpc,
  input  logic [AW-1:0] jpc,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] imem_rdata,
  input  logic          imem_rvalid,
  output logic          dec_valid,
  input  logic          dec_ready,
  output logic [DW-1:0] inst,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] pc4
`ifdef IF_ALIGN_CHK_EN
  ,
  output logic          misalign
`endif
);

  localparam int            CW     = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0] STEP_A = AW'(DW / 8);

  typedef struct packed {
    logic [DW-1:0] inst;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc4;
  } entry_t;

  logic [AW-1:0] pc_r;
  logic          epoch_r;
  logic          inflight_r;
  logic          tag_r;
  logic [AW-1:0] req_addr_r;

  logic          redirect_s;
  logic [AW-1:0] target_raw_s;
  logic [AW-1:0] target_s;
  logic [CW:0]   occupancy_s;
  logic          issue_s;
  logic          push_s;
  logic          pop_s;
  logic [CW-1:0] count_s;
  logic          empty_s;
  entry_t        din_s;
  entry_t        head_s;
`ifdef IF_ALIGN_CHK_EN
  logic          misalign_s;
`endif

  assign redirect_s = (pcsrc_e'(pcsource) != PCSRC_SEQ);

  // Raw redirect target from the PC source select.
  always_comb begin
    target_raw_s = pc_r;
    case (pcsrc_e'(pcsource))
      PCSRC_BR:  target_raw_s = bpc;
      PCSRC_JMP: target_raw_s = jpc;
      PCSRC_EXC: target_raw_s = EXC_VEC;
      default:   target_raw_s = pc_r;
    endcase
  end

  // Alignment policy for redirect targets.
  always_comb begin
`ifdef IF_ALIGN_CHK_EN
    misalign_s = redirect_s && ((target_raw_s & (STEP_A - AW'(1))) != AW'(0));
    target_s   = misalign_s ? EXC_VEC : target_raw_s;
`else
    target_s   = target_raw_s & ~(STEP_A - AW'(1));
`endif
  end

  // Credit: queued entries plus the one response still on its way must leave
  // room, so a response can always be pushed without overflow.
  assign occupancy_s = {1'b0, count_s} + {{CW{1'b0}}, inflight_r};
  assign issue_s     = clrn && !redirect_s && (occupancy_s < (CW+1)'(DEPTH));

  // A response is kept only if it belongs to the current epoch and no
  // redirect is flushing the queue in this very cycle.
  assign push_s    = imem_rvalid && inflight_r && (tag_r == epoch_r) && !redirect_s;
  assign dec_valid = !empty_s;
  assign pop_s     = dec_valid && dec_ready;

  assign din_s.inst = imem_rdata;
  assign din_s.pc   = req_addr_r;
  assign din_s.pc4  = req_addr_r + STEP_A;

  // PC, epoch and in-flight request tracking.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pc_r       <= RESET_PC;
      epoch_r    <= 1'b0;
      inflight_r <= 1'b0;
      tag_r      <= 1'b0;
      req_addr_r <= '0;
    end else if (redirect_s) begin
      pc_r       <= target_s;
      epoch_r    <= ~epoch_r;
      inflight_r <= 1'b0;
    end else if (issue_s) begin
      pc_r       <= pc_r + STEP_A;
      inflight_r <= 1'b1;
      tag_r      <= epoch_r;
      req_addr_r <= pc_r;
    end else begin
      inflight_r <= 1'b0;
    end
  end

  if_fetch_queue #(.DEPTH(DEPTH), .entry_t(entry_t)) u_queue (
    .clk   (clk),
    .clrn  (clrn),
    .push  (push_s),
    .pop   (pop_s),
    .flush (redirect_s),
    .din   (din_s),
    .dout  (head_s),
    .count (count_s),
    .empty (empty_s)
  );

  // Output drive; head fields are forced to zero while the queue is empty.
  always_comb begin
    imem_req  = issue_s;
    imem_addr = pc_r;
    inst      = '0;
    pc        = '0;
    pc4       = '0;
    if (dec_valid) begin
      inst = head_s.inst;
      pc   = head_s.pc;
      pc4  = head_s.pc4;
    end else begin
      inst = '0;
      pc   = '0;
      pc4  = '0;
    end
`ifdef IF_ALIGN_CHK_EN
    misalign = clrn && misalign_s;
`endif
  end

endmodule

// File: tb/tb_if_prefetch_stage.sv
module tb_if_prefetch_stage;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic [1:0]  pcsource;
  logic [31:0] bpc, jpc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] inst, pc, pc4;
`ifdef IF_ALIGN_CHK_EN
  logic        misalign;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  if_prefetch_stage dut (
    .clk         (clk),
    .clrn        (clrn),
    .pcsource    (pcsource),
    .bpc         (bpc),
    .jpc         (jpc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_rvalid (imem_rvalid),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .inst        (inst),
    .pc          (pc),
    .pc4         (pc4)
`ifdef IF_ALIGN_CHK_EN
    ,
    .misalign    (misalign)
`endif
  );

  // Instruction memory content: a fixed scramble of the address.
  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Memory responder: answers one cycle after each request seen at an edge.
  logic        rsp_v = 1'b0;
  logic [31:0] rsp_a = 32'h0;
  always @(posedge clk) begin
    rsp_v <= imem_req;
    rsp_a <= imem_addr;
  end

  // Reference model: next fetch PC, queue of fetched PCs, pending response.
  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  bit          m_infl;
  logic [31:0] m_infl_addr;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    m_q.delete();
    m_infl = 1'b0;
    m_infl_addr = 32'h0;
  endtask

  task automatic check_reset();
    check_val("rst_req",   {31'h0, imem_req},  32'h0);
    check_val("rst_addr",  imem_addr,          32'h0);
    check_val("rst_valid", {31'h0, dec_valid}, 32'h0);
    check_val("rst_inst",  inst,               32'h0);
    check_val("rst_pc",    pc,                 32'h0);
    check_val("rst_pc4",   pc4,                32'h0);
`ifdef IF_ALIGN_CHK_EN
    check_val("rst_misalign", {31'h0, misalign}, 32'h0);
`endif
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic step(input logic [1:0] ps, input logic [31:0] b, input logic [31:0] j, input logic rdy);
    logic [31:0] t;
    logic [31:0] h;
    bit redir, ereq, edv, emis;
    @(negedge clk);
    pcsource    = ps;
    bpc         = b;
    jpc         = j;
    dec_ready   = rdy;
    imem_rvalid = rsp_v;
    imem_rdata  = rsp_v ? data_of(rsp_a) : 32'h0;
    #1;
    redir = (ps != 2'b00);
    case (ps)
      2'b01:   t = b;
      2'b10:   t = j;
      2'b11:   t = 32'h8;
      default: t = m_pc;
    endcase
    emis = 1'b0;
`ifdef IF_ALIGN_CHK_EN
    if (redir && (t[1:0] != 2'b00)) begin
      emis = 1'b1;
      t = 32'h8;
    end
`else
    t = t & 32'hFFFF_FFFC;
`endif
    ereq = !redir && ((m_q.size() + int'(m_infl)) < 4);
    edv  = (m_q.size() > 0);
    h    = edv ? m_q[0] : 32'h0;
    check_val("imem_req",  {31'h0, imem_req},  {31'h0, ereq});
    check_val("imem_addr", imem_addr,          m_pc);
    check_val("dec_valid", {31'h0, dec_valid}, {31'h0, edv});
    check_val("inst",      inst,               edv ? data_of(h) : 32'h0);
    check_val("pc",        pc,                 h);
    check_val("pc4",       pc4,                edv ? h + 32'h4 : 32'h0);
`ifdef IF_ALIGN_CHK_EN
    check_val("misalign",  {31'h0, misalign},  {31'h0, emis});
`else
    if (emis) check_val("misalign_model", 32'h1, 32'h0);
`endif
    if (edv && rdy) void'(m_q.pop_front());
    if (redir) begin
      m_q.delete();
      m_pc   = t;
      m_infl = 1'b0;
    end else begin
      if (m_infl) m_q.push_back(m_infl_addr);
      if (ereq) begin
        m_infl_addr = m_pc;
        m_pc = m_pc + 32'h4;
      end
      m_infl = ereq;
    end
  endtask

  task automatic random_steps(input int n);
    logic [1:0]  ps;
    logic [31:0] b, j;
    logic        rdy;
    for (int i = 0; i < n; i++) begin
      ps = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      b = $urandom;
      j = $urandom;
      if ($urandom_range(0, 3) != 0) b[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) j[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFF0 | (b & 32'hC);
      rdy = ($urandom_range(0, 3) != 0);
      step(ps, b, j, rdy);
    end
  endtask

  initial begin
    pcsource = 2'b01; bpc = 32'h102; jpc = 32'h0;
    dec_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_reset();
    pcsource = 2'b00;
    @(posedge clk);
    #1 clrn = 1'b1;

    // Streaming with decode always ready.
    repeat (20) step(2'b00, 32'h0, 32'h0, 1'b1);
    // Decode stall: queue fills, fetch stops, then drains in order.
    repeat (10) step(2'b00, 32'h0, 32'h0, 1'b0);
    check_val("stall_full", {30'h0, dec_valid, imem_req}, 32'h2);
    repeat (10) step(2'b00, 32'h0, 32'h0, 1'b1);
    // Branch while a request is in flight.
    step(2'b01, 32'h100, 32'h0, 1'b1);
    repeat (6) step(2'b00, 32'h0, 32'h0, 1'b1);
    // Exception on the same cycle as a pop from a partly full queue.
    repeat (3) step(2'b00, 32'h0, 32'h0, 1'b0);
    step(2'b11, 32'h0, 32'h0, 1'b1);
    repeat (6) step(2'b00, 32'h0, 32'h0, 1'b1);
    // PC wrap at the top of the address space.
    step(2'b01, 32'hFFFF_FFF8, 32'h0, 1'b1);
    repeat (8) step(2'b00, 32'h0, 32'h0, 1'b1);
    // Misaligned jump target.
    step(2'b10, 32'h0, 32'h102, 1'b1);
    repeat (5) step(2'b00, 32'h0, 32'h0, 1'b1);
    // Back-to-back redirects: last one wins.
    step(2'b01, 32'h200, 32'h0, 1'b1);
    step(2'b10, 32'h0, 32'h300, 1'b0);
    repeat (6) step(2'b00, 32'h0, 32'h0, 1'b1);

    random_steps(1500);

    // Reset in the middle of operation discards everything.
    #2 clrn = 1'b0;
    #1;
    check_reset();
    @(posedge clk);
    #1;
    model_reset();
    clrn = 1'b1;
    random_steps(300);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
